tune_sequencer: RTL and testbench
=================================

# tune_sequencer

Note sequencer for the tone synthesis path. It walks a synchronous note ROM and issues one frequency control word (FCW) per note. For each note it holds the FCW and a gate for a programmable number of tempo ticks, then inserts an articulation gap before the next note. Its `fcw`/`gate` outputs replace the free-running 32-entry tune stepping in front of the harmonic DDS bank and PWM stage; `gate` low forces silence downstream.

## Interface
- `ADDR_W`, 5, note ROM address width (up to 32 notes)
- `FCW_W`, 24, FCW width, matching the DDS phase increment
- `DUR_W`, 4, duration field width
- `TICK_DIV`, 390625, clk cycles per tempo tick (≥2)
- `GAP_TICKS`, 1, silent ticks after each note (0 = legato, no gap)

Ports:
- `clk`  in  1  single system clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins playback at address 0 when idle
- `stop`  in  1  one-cycle pulse; aborts playback
- `loop_en`  in  1  sampled at end of sequence; 1 = restart at address 0
- `rom_addr`  out  ADDR_W  note ROM address
- `rom_data`  in  1+DUR_W+FCW_W  entry {last, dur, fcw}, valid 1 cycle after `rom_addr`
- `fcw`  out  FCW_W  registered FCW to the DDS bank
- `gate`  out  1  1 = note sounding
- `note_idx`  out  ADDR_W  address of the note currently held on `fcw`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when a non-looping sequence finishes

## Operation
- Reset values: `rom_addr`=0, `fcw`=0, `gate`=0, `note_idx`=0, `busy`=0, `done`=0, state IDLE, prescaler 0, tick counter 0.
- States:
  - IDLE → FETCH on `start`.
  - FETCH: `rom_addr` stable, 1 cycle → LATCH.
  - LATCH: capture `rom_data`; load `fcw`, `note_idx`=`rom_addr`; `gate`=1 unless fcw field==0 (rest: `gate`=0). Clear prescaler, load tick counter with dur. → PLAY.
  - PLAY: lasts (dur+1) ticks → GAP, or → NEXT if `GAP_TICKS`==0.
  - GAP: `gate`=0, `fcw` held, lasts `GAP_TICKS` ticks → NEXT.
  - NEXT, 1 cycle:
    - last=0: `rom_addr`+1 → FETCH.
    - last=1 and `loop_en`=1: `rom_addr`=0 → FETCH.
    - last=1 and `loop_en`=0: `done`=1, `fcw`=0 → IDLE.
- Address wrap: `rom_addr` incrementing from 2^ADDR_W−1 wraps to 0. No end is implied at the wrap; only the last bit ends a sequence.
- Prescaler counts 0..TICK_DIV−1. It advances only in PLAY/GAP, and a tick fires when it reaches TICK_DIV−1.
- `start` while `busy` is ignored. `stop` from any state → IDLE next cycle with `gate`=0, `fcw`=0, `rom_addr`=0, no `done`. `start` and `stop` in the same cycle: `stop` wins.
- `reset` mid-note: all outputs return to reset values the next cycle.

## Timing
- `start` at cycle 0 → FETCH at 1, LATCH at 2, `fcw`/`gate` valid from cycle 3.
- PLAY occupies exactly (dur+1)·TICK_DIV cycles. GAP occupies GAP_TICKS·TICK_DIV cycles.
- Inter-note overhead is 3 cycles (NEXT, FETCH, LATCH). During these `fcw` keeps the old value and `gate` stays 0. With GAP_TICKS=0, `gate` drops only for these 3 cycles.
- Note period = (dur+1+GAP_TICKS)·TICK_DIV + 3 cycles.
- `done` is asserted in the same cycle `busy` falls.

## Structure
- A shared package `tune_pkg` holds: the entry field offsets (LAST_BIT, DUR_LSB, FCW_LSB), the state encoding enum, and the default FCW_W/ADDR_W constants shared with the DDS wrapper.
- One sub-module, `tick_prescaler`, with inputs clear and enable and output tick pulse, parameterised by TICK_DIV.
- The FSM and datapath registers stay in `tune_sequencer`.
- The note ROM is external and synchronous; the sequencer contains no memory.

## Test plan
All scenarios use TICK_DIV=4, GAP_TICKS=1 unless stated.
- **Single note:** ROM[0]={1,2,0x00A000}; `start` at cycle 0 → `fcw`=0x00A000 and `gate`=1 over cycles 3–14; `gate`=0 over 15–18; `done` at cycle 19; `busy` low from 19.
- **Three-note sequence:** last bit on entry 2 → `note_idx` steps 0,1,2. Each note start is separated by (dur+2)·4+3 cycles. A single `done` pulse.
- **Rest:** fcw field 0 → `gate` stays 0 for the full duration; `note_idx` still advances.
- **Loop:** `loop_en`=1 with 2 notes → after entry 1, `rom_addr` returns to 0 and no `done`. Then `stop` mid-PLAY → next cycle `gate`=0, `fcw`=0, `busy`=0, no `done`.
- **Edge cases:**
  - `start` while busy → ignored, timing unchanged.
  - `start` and `stop` in the same cycle while IDLE → stays IDLE.
  - GAP_TICKS=0 → `gate` low exactly 3 cycles between notes.
- **Reset and wrap:**
  - `reset` asserted in GAP → all outputs at reset values the next cycle.
  - 32 entries with no last bit → `rom_addr` wraps 31→0 and playback continues.

Source files
------------

// File: rtl/tune_pkg.sv
// Shared definitions for the tone synthesis path: default widths, note ROM
// entry layout {last, dur, fcw} and the sequencer state encoding.
package tune_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned FCW_W_DEF  = 24;
  localparam int unsigned DUR_W_DEF  = 4;

  // Entry field offsets for the default widths.
  localparam int unsigned FCW_LSB  = 0;
  localparam int unsigned DUR_LSB  = FCW_LSB + FCW_W_DEF;
  localparam int unsigned LAST_BIT = DUR_LSB + DUR_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_PLAY,
    ST_GAP,
    ST_NEXT
  } seq_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Tempo tick prescaler: counts 0..TICK_DIV-1 while enabled, pulses tick on
// the terminal count. clear returns the count to 0 and wins over enable.
// Ports: clk, reset (sync, active high), clear, enable, tick.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 390625
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned      CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tune_sequencer.sv
// Note sequencer: walks an external synchronous note ROM and issues one FCW
// plus gate per note, holding it for (dur+1) tempo ticks, then GAP_TICKS
// silent ticks before the next note.
// Ports: clk, reset (sync, active high), start/stop pulses, loop_en,
// rom_addr/rom_data ROM port, fcw/gate/note_idx to the DDS bank,
// busy (not idle) and done (non-looping sequence finished).
module tune_sequencer
  import tune_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned FCW_W     = FCW_W_DEF,
  parameter int unsigned DUR_W     = DUR_W_DEF,
  parameter int unsigned TICK_DIV  = 390625,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DUR_W+FCW_W:0]     rom_data,
  output logic [FCW_W-1:0]         fcw,
  output logic                     gate,
  output logic [ADDR_W-1:0]        note_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned DUR_OFS  = FCW_LSB + FCW_W;
  localparam int unsigned LAST_OFS = DUR_OFS + DUR_W;

  // Tick counter must hold both dur and GAP_TICKS-1.
  localparam int unsigned GAP_W  = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS);
  localparam int unsigned TCNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;
  localparam logic [TCNT_W-1:0] GAP_LOAD =
    (GAP_TICKS == 0) ? '0 : TCNT_W'(GAP_TICKS - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [FCW_W-1:0]  fcw_q, fcw_d;
  logic              gate_q, gate_d;
  logic [ADDR_W-1:0] note_idx_q, note_idx_d;
  logic              last_q, last_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  logic              tick;
  logic              presc_clear;
  logic              presc_en;

  logic [FCW_W-1:0]  rd_fcw;
  logic [DUR_W-1:0]  rd_dur;
  logic              rd_last;

  assign rd_fcw  = rom_data[FCW_LSB +: FCW_W];
  assign rd_dur  = rom_data[DUR_OFS +: DUR_W];
  assign rd_last = rom_data[LAST_OFS];

  assign presc_clear = (state_q == ST_LATCH);
  assign presc_en    = (state_q == ST_PLAY) || (state_q == ST_GAP);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (presc_clear),
    .enable (presc_en),
    .tick   (tick)
  );

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    fcw_d      = fcw_q;
    gate_d     = gate_q;
    note_idx_d = note_idx_q;
    last_d     = last_q;
    tcnt_d     = tcnt_q;
    done       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rom_addr_d = '0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        fcw_d      = rd_fcw;
        gate_d     = (rd_fcw != '0);
        note_idx_d = rom_addr_q;
        last_d     = rd_last;
        tcnt_d     = TCNT_W'(rd_dur);
        state_d    = ST_PLAY;
      end
      ST_PLAY: begin
        if (tick) begin
          if (tcnt_q == '0) begin
            gate_d = 1'b0;
            if (GAP_TICKS == 0) begin
              state_d = ST_NEXT;
            end else begin
              tcnt_d  = GAP_LOAD;
              state_d = ST_GAP;
            end
          end else begin
            tcnt_d = tcnt_q - 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (tcnt_q == '0) state_d = ST_NEXT;
          else              tcnt_d  = tcnt_q - 1'b1;
        end
      end
      ST_NEXT: begin
        if (!last_q) begin
          rom_addr_d = rom_addr_q + 1'b1;
          state_d    = ST_FETCH;
        end else if (loop_en) begin
          rom_addr_d = '0;
          state_d    = ST_FETCH;
        end else begin
          done       = 1'b1;
          fcw_d      = '0;
          rom_addr_d = '0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (stop) begin
      state_d    = ST_IDLE;
      gate_d     = 1'b0;
      fcw_d      = '0;
      rom_addr_d = '0;
      done       = 1'b0;
    end

    // busy drops in the same cycle the done pulse is issued.
    busy = (state_q != ST_IDLE) && !done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      fcw_q      <= '0;
      gate_q     <= 1'b0;
      note_idx_q <= '0;
      last_q     <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      fcw_q      <= fcw_d;
      gate_q     <= gate_d;
      note_idx_q <= note_idx_d;
      last_q     <= last_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign fcw      = fcw_q;
  assign gate     = gate_q;
  assign note_idx = note_idx_q;

endmodule

// File: tb/tb_tune_sequencer.sv
module tb_tune_sequencer;

  localparam int AW = 5;
  localparam int FW = 24;
  localparam int DW = 4;
  localparam int EW = 1 + DW + FW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start, stop, loop_en;
  logic [AW-1:0] rom_addr;
  logic [EW-1:0] rom_data;
  logic [FW-1:0] fcw;
  logic          gate;
  logic [AW-1:0] note_idx;
  logic          busy, done;
  logic [EW-1:0] rom [32];

  logic          start0, stop0, loop_en0;
  logic [AW-1:0] rom_addr0;
  logic [EW-1:0] rom_data0;
  logic [FW-1:0] fcw0;
  logic          gate0;
  logic [AW-1:0] note_idx0;
  logic          busy0, done0;
  logic [EW-1:0] rom0 [32];

  always @(posedge clk) rom_data  <= rom[rom_addr];
  always @(posedge clk) rom_data0 <= rom0[rom_addr0];

  tune_sequencer #(
    .ADDR_W(AW), .FCW_W(FW), .DUR_W(DW), .TICK_DIV(4), .GAP_TICKS(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .fcw(fcw), .gate(gate),
    .note_idx(note_idx), .busy(busy), .done(done)
  );

  tune_sequencer #(
    .ADDR_W(AW), .FCW_W(FW), .DUR_W(DW), .TICK_DIV(4), .GAP_TICKS(0)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start0), .stop(stop0), .loop_en(loop_en0),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .fcw(fcw0), .gate(gate0),
    .note_idx(note_idx0), .busy(busy0), .done(done0)
  );

  typedef struct {
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [AW-1:0] addr;
    logic [FW-1:0] fcw;
    logic          gate;
    logic [AW-1:0] idx;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [EW-1:0] entry(logic last, logic [DW-1:0] dur, logic [FW-1:0] f);
    return {last, dur, f};
  endfunction

  task automatic add(input int n, input logic s, input logic p, input logic l,
                     input logic [AW-1:0] a, input logic [FW-1:0] f, input logic g,
                     input logic [AW-1:0] i, input logic b, input logic d);
    vec_t v;
    v.start = s; v.stop = p; v.loop_en = l; v.addr = a; v.fcw = f;
    v.gate = g; v.idx = i; v.busy = b; v.done = d;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One vector per cycle: inputs applied at the falling edge, outputs checked just after.
  task automatic run_vecs(input string name);
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      start   = vecs[k].start;
      stop    = vecs[k].stop;
      loop_en = vecs[k].loop_en;
      #1;
      n_cmp++;
      if ({rom_addr, fcw, gate, note_idx, busy, done} !==
          {vecs[k].addr, vecs[k].fcw, vecs[k].gate, vecs[k].idx, vecs[k].busy, vecs[k].done}) begin
        n_bad++;
        $display("FAIL %s[%0d]: got addr=%0d fcw=%h gate=%b idx=%0d busy=%b done=%b, expected addr=%0d fcw=%h gate=%b idx=%0d busy=%b done=%b",
                 name, k, rom_addr, fcw, gate, note_idx, busy, done,
                 vecs[k].addr, vecs[k].fcw, vecs[k].gate, vecs[k].idx, vecs[k].busy, vecs[k].done);
      end
    end
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc, hi, lo;
    logic saw_done;

    for (int i = 0; i < 32; i++) begin rom[i] = '0; rom0[i] = '0; end
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    start0 = 1'b0; stop0 = 1'b0; loop_en0 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {rom_addr, fcw, gate, note_idx, busy, done}, '0);
    reset = 1'b0;

    // Single note {1,2,0x00A000}; a start in the middle of PLAY is ignored.
    rom[0] = entry(1'b1, 4'd2, 24'h00A000);
    add(1, 1, 0, 0, 0, 24'h0,      0, 0, 0, 0);
    add(2, 0, 0, 0, 0, 24'h0,      0, 0, 1, 0);
    add(4, 0, 0, 0, 0, 24'h00A000, 1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 24'h00A000, 1, 0, 1, 0);
    add(7, 0, 0, 0, 0, 24'h00A000, 1, 0, 1, 0);
    add(4, 0, 0, 0, 0, 24'h00A000, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 24'h00A000, 0, 0, 0, 1);
    add(2, 0, 0, 0, 0, 24'h0,      0, 0, 0, 0);
    run_vecs("single");

    // Two-note loop, then stop mid-PLAY.
    rom[0] = entry(1'b0, 4'd1, 24'h001000);
    rom[1] = entry(1'b1, 4'd0, 24'h002000);
    add(1, 1, 0, 1, 0, 24'h0,      0, 0, 0, 0);
    add(2, 0, 0, 1, 0, 24'h0,      0, 0, 1, 0);
    add(8, 0, 0, 1, 0, 24'h001000, 1, 0, 1, 0);
    add(4, 0, 0, 1, 0, 24'h001000, 0, 0, 1, 0);
    add(1, 0, 0, 1, 0, 24'h001000, 0, 0, 1, 0);
    add(2, 0, 0, 1, 1, 24'h001000, 0, 0, 1, 0);
    add(4, 0, 0, 1, 1, 24'h002000, 1, 1, 1, 0);
    add(4, 0, 0, 1, 1, 24'h002000, 0, 1, 1, 0);
    add(1, 0, 0, 1, 1, 24'h002000, 0, 1, 1, 0);
    add(2, 0, 0, 1, 0, 24'h002000, 0, 1, 1, 0);
    add(2, 0, 0, 1, 0, 24'h001000, 1, 0, 1, 0);
    add(1, 0, 1, 1, 0, 24'h001000, 1, 0, 1, 0);
    add(2, 0, 0, 0, 0, 24'h0,      0, 0, 0, 0);
    run_vecs("loop_stop");

    // Three notes with a rest in the middle, then start+stop together while idle.
    rom[0] = entry(1'b0, 4'd0, 24'h000100);
    rom[1] = entry(1'b0, 4'd1, 24'h000000);
    rom[2] = entry(1'b1, 4'd0, 24'h000300);
    add(1, 1, 0, 0, 0, 24'h0,      0, 0, 0, 0);
    add(2, 0, 0, 0, 0, 24'h0,      0, 0, 1, 0);
    add(4, 0, 0, 0, 0, 24'h000100, 1, 0, 1, 0);
    add(4, 0, 0, 0, 0, 24'h000100, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 24'h000100, 0, 0, 1, 0);
    add(2, 0, 0, 0, 1, 24'h000100, 0, 0, 1, 0);
    add(8, 0, 0, 0, 1, 24'h0,      0, 1, 1, 0);
    add(4, 0, 0, 0, 1, 24'h0,      0, 1, 1, 0);
    add(1, 0, 0, 0, 1, 24'h0,      0, 1, 1, 0);
    add(2, 0, 0, 0, 2, 24'h0,      0, 1, 1, 0);
    add(4, 0, 0, 0, 2, 24'h000300, 1, 2, 1, 0);
    add(4, 0, 0, 0, 2, 24'h000300, 0, 2, 1, 0);
    add(1, 0, 0, 0, 2, 24'h000300, 0, 2, 0, 1);
    add(2, 0, 0, 0, 0, 24'h0,      0, 2, 0, 0);
    add(1, 1, 1, 0, 0, 24'h0,      0, 2, 0, 0);
    add(3, 0, 0, 0, 0, 24'h0,      0, 2, 0, 0);
    run_vecs("three_note");

    // Legato (GAP_TICKS=0): gate low exactly 3 cycles between notes.
    rom0[0] = entry(1'b0, 4'd0, 24'h000111);
    rom0[1] = entry(1'b1, 4'd0, 24'h000222);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0; cyc = 1;
    while (!gate0 && cyc < 20) begin @(negedge clk); cyc++; end
    check("legato_first_gate_cycle", 64'(cyc), 64'd3);
    hi = 0;
    while (gate0 && hi < 20) begin @(negedge clk); hi++; end
    check("legato_note0_high", 64'(hi), 64'd4);
    lo = 0;
    while (!gate0 && lo < 20) begin @(negedge clk); lo++; end
    check("legato_gap_low", 64'(lo), 64'd3);
    check("legato_note1", {fcw0, note_idx0}, {24'h000222, 5'd1});
    hi = 0;
    while (gate0 && hi < 20) begin @(negedge clk); hi++; end
    check("legato_note1_high", 64'(hi), 64'd4);
    check("legato_done", {done0, busy0}, 2'b10);

    // Reset asserted during GAP.
    rom[0] = entry(1'b1, 4'd2, 24'h00A000);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    check("in_gap", {fcw, gate, busy}, {24'h00A000, 1'b0, 1'b1});
    reset = 1'b1;
    @(negedge clk);
    check("reset_in_gap", {rom_addr, fcw, gate, note_idx, busy, done}, '0);
    reset = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("restart_c3", {fcw, gate}, {24'h00A000, 1'b1});
    repeat (11) @(negedge clk);
    check("restart_c14", {gate}, 1'b1);
    @(negedge clk);
    check("restart_c15", {gate}, 1'b0);
    lo = 0;
    while (busy && lo < 20) begin @(negedge clk); lo++; end
    check("restart_idle", {busy, lo < 20}, 2'b01);

    // 32 entries, no last bit: address wraps 31 -> 0 and playback continues.
    for (int i = 0; i < 32; i++) rom[i] = entry(1'b0, 4'd0, 24'(i + 1));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    saw_done = 1'b0; lo = 0;
    while (rom_addr != 5'd31 && lo < 500) begin saw_done |= done; @(negedge clk); lo++; end
    check("wrap_reach_31", {rom_addr}, 5'd31);
    lo = 0;
    while (rom_addr == 5'd31 && lo < 20) begin saw_done |= done; @(negedge clk); lo++; end
    check("wrap_to_0", {rom_addr, busy}, {5'd0, 1'b1});
    lo = 0;
    while (!(gate && note_idx == 5'd0) && lo < 20) begin saw_done |= done; @(negedge clk); lo++; end
    check("wrap_replay_entry0", {fcw, note_idx, gate}, {24'h000001, 5'd0, 1'b1});
    check("wrap_no_done", {saw_done}, 1'b0);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("wrap_stop", {rom_addr, fcw, gate, busy, done}, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
